voice_allocator: RTL and testbench

//  Schedules NUM_VOICES shared oscillator/envelope voices between incoming MIDI note events.

---
 rtl/synth_pkg.sv | 10 +
 rtl/voice_slot.sv | 52 +++++
 rtl/voice_allocator.sv | 199 +++++++++++++++++++
 tb/tb_voice_allocator.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// Shared types and MIDI field widths for the voice allocator and its voice slots.
package synth_pkg;

  localparam int MIDI_NOTE_W = 7;
  localparam int MIDI_VEL_W  = 7;

  typedef enum logic [1:0] {V_FREE, V_ACTIVE, V_RELEASING} voice_state_t;
  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_COMMIT} alloc_state_t;

endpackage

// File: rtl/voice_slot.sv
// One voice of the pool: holds state, note, velocity, allocation stamp and release countdown.
module voice_slot
  import synth_pkg::*;
#(
  parameter int STAMP_W = 8,
  parameter int REL_W   = 9
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   tick,
  input  logic                   do_assign,
  input  logic                   do_release,
  input  logic [MIDI_NOTE_W-1:0] note_in,
  input  logic [MIDI_VEL_W-1:0]  vel_in,
  input  logic [STAMP_W-1:0]     stamp_in,
  input  logic [REL_W-1:0]       rel_len,
  output voice_state_t           state,
  output logic [MIDI_NOTE_W-1:0] note,
  output logic [MIDI_VEL_W-1:0]  vel,
  output logic [STAMP_W-1:0]     stamp,
  output logic                   trig
);

  logic [REL_W-1:0] rel_cnt;

  // Commands from the allocator take priority over a coincident tick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= V_FREE;
      note    <= '0;
      vel     <= '0;
      stamp   <= '0;
      rel_cnt <= '0;
      trig    <= 1'b0;
    end else begin
      trig <= do_assign;
      if (do_assign) begin
        state <= V_ACTIVE;
        note  <= note_in;
        vel   <= vel_in;
        stamp <= stamp_in;
      end else if (do_release) begin
        state   <= V_RELEASING;
        rel_cnt <= rel_len;
      end else if (state == V_RELEASING && tick) begin
        rel_cnt <= rel_cnt - 1'b1;
        if (rel_cnt == REL_W'(1)) state <= V_FREE;
      end
    end
  end

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: sequential scan of the voice pool per MIDI event.
// Define VOICE_STEAL_EN to steal the oldest active voice when the pool is full.
module voice_allocator
  import synth_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int REL_TICKS  = 64,
  parameter int STAMP_W    = 8
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              ev_valid,
  output logic                              ev_ready,
  input  logic                              ev_note_on,
  input  logic [MIDI_NOTE_W-1:0]            ev_note,
  input  logic [MIDI_VEL_W-1:0]             ev_vel,
  input  logic                              tick,
  input  logic [1:0]                        rel_sel,
  output logic [NUM_VOICES-1:0]             voice_gate,
  output logic [NUM_VOICES-1:0]             voice_busy,
  output logic [NUM_VOICES-1:0]             voice_trig,
  output logic [NUM_VOICES*MIDI_NOTE_W-1:0] voice_note,
  output logic [NUM_VOICES*MIDI_VEL_W-1:0]  voice_vel,
  output logic                              drop_pulse
);

  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int REL_W = $clog2(4 * REL_TICKS + 1);

  alloc_state_t state, state_nxt;

  logic [IDX_W-1:0]       scan_k;
  logic                   ev_on_q;
  logic [MIDI_NOTE_W-1:0] ev_note_q;
  logic [MIDI_VEL_W-1:0]  ev_vel_q;
  logic [STAMP_W-1:0]     stamp_now;

  logic                   match_found, free_found, rel_found;
  logic [IDX_W-1:0]       match_idx, free_idx, rel_idx;
  logic [STAMP_W-1:0]     rel_age;
`ifdef VOICE_STEAL_EN
  logic                   act_found;
  logic [IDX_W-1:0]       act_idx;
  logic [STAMP_W-1:0]     act_age;
`endif

  voice_state_t           slot_state [NUM_VOICES];
  logic [MIDI_NOTE_W-1:0] slot_note  [NUM_VOICES];
  logic [MIDI_VEL_W-1:0]  slot_vel   [NUM_VOICES];
  logic [STAMP_W-1:0]     slot_stamp [NUM_VOICES];

  logic [NUM_VOICES-1:0]  assign_vec, release_vec;
  logic                   do_assign;
  logic [IDX_W-1:0]       sel_idx;
  logic                   handshake, last_k;
  voice_state_t           cur_state;
  logic [MIDI_NOTE_W-1:0] cur_note;
  logic [STAMP_W-1:0]     cur_age;
  logic [REL_W-1:0]       rel_len;

  assign ev_ready  = (state == S_IDLE);
  assign handshake = ev_valid && ev_ready;
  assign last_k    = (scan_k == IDX_W'(NUM_VOICES - 1));
  assign cur_state = slot_state[scan_k];
  assign cur_note  = slot_note[scan_k];
  assign cur_age   = stamp_now - slot_stamp[scan_k];
  assign rel_len   = REL_W'((32'(rel_sel) + 32'd1) * REL_TICKS);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    do_assign   = 1'b0;
    sel_idx     = '0;
    drop_pulse  = 1'b0;
    assign_vec  = '0;
    release_vec = '0;
    unique case (state)
      S_IDLE:   if (handshake) state_nxt = S_SCAN;
      S_SCAN:   if (last_k)    state_nxt = S_COMMIT;
      S_COMMIT: begin
        state_nxt = S_IDLE;
        if (ev_on_q) begin
          if (match_found) begin
            do_assign = 1'b1;
            sel_idx   = match_idx;
          end else if (free_found) begin
            do_assign = 1'b1;
            sel_idx   = free_idx;
          end else if (rel_found) begin
            do_assign = 1'b1;
            sel_idx   = rel_idx;
`ifdef VOICE_STEAL_EN
          end else if (act_found) begin
            do_assign = 1'b1;
            sel_idx   = act_idx;
`endif
          end else begin
            drop_pulse = 1'b1;
          end
        end else if (match_found) begin
          release_vec[match_idx] = 1'b1;
        end
        if (do_assign) assign_vec[sel_idx] = 1'b1;
      end
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Candidate registers; strict '>' on age keeps the lowest index on ties.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scan_k      <= '0;
      ev_on_q     <= 1'b0;
      ev_note_q   <= '0;
      ev_vel_q    <= '0;
      stamp_now   <= '0;
      match_found <= 1'b0;
      free_found  <= 1'b0;
      rel_found   <= 1'b0;
      match_idx   <= '0;
      free_idx    <= '0;
      rel_idx     <= '0;
      rel_age     <= '0;
`ifdef VOICE_STEAL_EN
      act_found   <= 1'b0;
      act_idx     <= '0;
      act_age     <= '0;
`endif
    end else begin
      if (handshake) begin
        ev_on_q     <= ev_note_on && (ev_vel != '0);
        ev_note_q   <= ev_note;
        ev_vel_q    <= ev_vel;
        scan_k      <= '0;
        match_found <= 1'b0;
        free_found  <= 1'b0;
        rel_found   <= 1'b0;
`ifdef VOICE_STEAL_EN
        act_found   <= 1'b0;
`endif
      end
      if (state == S_SCAN) begin
        scan_k <= scan_k + 1'b1;
        if (cur_state == V_ACTIVE && cur_note == ev_note_q && !match_found) begin
          match_found <= 1'b1;
          match_idx   <= scan_k;
        end
        if (cur_state == V_FREE && !free_found) begin
          free_found <= 1'b1;
          free_idx   <= scan_k;
        end
        if (cur_state == V_RELEASING && (!rel_found || cur_age > rel_age)) begin
          rel_found <= 1'b1;
          rel_idx   <= scan_k;
          rel_age   <= cur_age;
        end
`ifdef VOICE_STEAL_EN
        if (cur_state == V_ACTIVE && (!act_found || cur_age > act_age)) begin
          act_found <= 1'b1;
          act_idx   <= scan_k;
          act_age   <= cur_age;
        end
`endif
      end
      if (do_assign) stamp_now <= stamp_now + 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_VOICES; i++) begin : g_slot
    voice_slot #(
      .STAMP_W(STAMP_W),
      .REL_W  (REL_W)
    ) u_slot (
      .clk       (clk),
      .reset_n   (reset_n),
      .tick      (tick),
      .do_assign (assign_vec[i]),
      .do_release(release_vec[i]),
      .note_in   (ev_note_q),
      .vel_in    (ev_vel_q),
      .stamp_in  (stamp_now),
      .rel_len   (rel_len),
      .state     (slot_state[i]),
      .note      (slot_note[i]),
      .vel       (slot_vel[i]),
      .stamp     (slot_stamp[i]),
      .trig      (voice_trig[i])
    );
    assign voice_gate[i] = (slot_state[i] == V_ACTIVE);
    assign voice_busy[i] = (slot_state[i] != V_FREE);
    assign voice_note[MIDI_NOTE_W*i +: MIDI_NOTE_W] = slot_note[i];
    assign voice_vel[MIDI_VEL_W*i +: MIDI_VEL_W]    = slot_vel[i];
  end

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator against a behavioural voice-pool model.
`timescale 1ns/1ps
module tb_voice_allocator;

  localparam int NV = 4;
  localparam int RT = 4;
  localparam int SW = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          ev_valid = 1'b0;
  logic          ev_note_on = 1'b0;
  logic [6:0]    ev_note = '0;
  logic [6:0]    ev_vel = '0;
  logic          tick = 1'b0;
  logic [1:0]    rel_sel = '0;
  logic          ev_ready, drop_pulse;
  logic [NV-1:0] voice_gate, voice_busy, voice_trig;
  logic [NV*7-1:0] voice_note, voice_vel;

  int checks = 0;
  int errors = 0;

  // Model: state 0 free, 1 held, 2 releasing; seq = allocation order (smaller = older)
  int m_state[NV];
  int m_note[NV];
  int m_vel[NV];
  int m_seq[NV];
  int m_rel[NV];
  int seq_ctr;

  always #5 clk = ~clk;

  voice_allocator #(
    .NUM_VOICES(NV),
    .REL_TICKS (RT),
    .STAMP_W   (SW)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ev_valid  (ev_valid),
    .ev_ready  (ev_ready),
    .ev_note_on(ev_note_on),
    .ev_note   (ev_note),
    .ev_vel    (ev_vel),
    .tick      (tick),
    .rel_sel   (rel_sel),
    .voice_gate(voice_gate),
    .voice_busy(voice_busy),
    .voice_trig(voice_trig),
    .voice_note(voice_note),
    .voice_vel (voice_vel),
    .drop_pulse(drop_pulse)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < NV; i++) begin
      m_state[i] = 0; m_note[i] = 0; m_vel[i] = 0; m_seq[i] = 0; m_rel[i] = 0;
    end
    seq_ctr = 0;
  endtask

  function automatic logic [NV-1:0] exp_busy();
    logic [NV-1:0] r = '0;
    for (int i = 0; i < NV; i++) r[i] = (m_state[i] != 0);
    return r;
  endfunction

  function automatic logic [NV-1:0] exp_gate();
    logic [NV-1:0] r = '0;
    for (int i = 0; i < NV; i++) r[i] = (m_state[i] == 1);
    return r;
  endfunction

  function automatic logic [NV*7-1:0] busy_mask();
    logic [NV*7-1:0] r = '0;
    for (int i = 0; i < NV; i++) if (m_state[i] != 0) r[7*i +: 7] = 7'h7f;
    return r;
  endfunction

  function automatic logic [NV*7-1:0] exp_notes();
    logic [NV*7-1:0] r = '0;
    for (int i = 0; i < NV; i++) if (m_state[i] != 0) r[7*i +: 7] = 7'(m_note[i]);
    return r;
  endfunction

  function automatic logic [NV*7-1:0] exp_vels();
    logic [NV*7-1:0] r = '0;
    for (int i = 0; i < NV; i++) if (m_state[i] != 0) r[7*i +: 7] = 7'(m_vel[i]);
    return r;
  endfunction

  task automatic model_event(input bit on, input int n, input int v, input int rs,
                             output logic [NV-1:0] et, output int ed);
    int idx = -1;
    et = '0;
    ed = 0;
    for (int i = 0; i < NV; i++) if (idx < 0 && m_state[i] == 1 && m_note[i] == n) idx = i;
    if (on && v != 0) begin
      for (int i = 0; i < NV; i++) if (idx < 0 && m_state[i] == 0) idx = i;
      for (int i = 0; i < NV; i++)
        if (m_state[i] == 2 && (idx < 0 || (m_state[idx] == 2 && m_seq[i] < m_seq[idx]))) idx = i;
`ifdef VOICE_STEAL_EN
      for (int i = 0; i < NV; i++)
        if (m_state[i] == 1 && (idx < 0 || (m_state[idx] == 1 && m_note[idx] != n && m_seq[i] < m_seq[idx]))) idx = i;
`endif
      if (idx < 0) ed = 1;
      else begin
        m_state[idx] = 1; m_note[idx] = n; m_vel[idx] = v; m_seq[idx] = seq_ctr++;
        et[idx] = 1'b1;
      end
    end else if (idx >= 0) begin
      m_state[idx] = 2;
      m_rel[idx] = (rs + 1) * RT;
    end
  endtask

  task automatic do_ticks(input int n);
    for (int t = 0; t < n; t++) begin
      tick = 1'b1; step(); tick = 1'b0; step();
      for (int i = 0; i < NV; i++)
        if (m_state[i] == 2) begin
          m_rel[i]--;
          if (m_rel[i] == 0) m_state[i] = 0;
        end
    end
  endtask

  // Drives one event and records what the DUT did over the fixed latency window.
  task automatic do_event(input bit on, input int n, input int v, input int rs, input bit tick_commit,
                          output logic [NV-1:0] trig_at, output int drop_cnt,
                          output bit ready_ok, output int trig_early);
    int w = 0;
    ev_note_on = on; ev_note = 7'(n); ev_vel = 7'(v); rel_sel = 2'(rs); ev_valid = 1'b1;
    while (!ev_ready && w < 50) begin step(); w++; end
    if (!ev_ready) begin
      checks++; errors++;
      $display("FAIL ev_ready_timeout: ev_ready=%b required 1", ev_ready);
    end
    ready_ok = 1; drop_cnt = 0; trig_early = 0; trig_at = '0;
    for (int c = 1; c <= NV + 2; c++) begin
      step();
      if (c == 1) ev_valid = 1'b0;
      if (c == NV + 2) tick = 1'b0;
      if (c <= NV + 1 && ev_ready) ready_ok = 0;
      if (c == NV + 2 && !ev_ready) ready_ok = 0;
      if (drop_pulse) drop_cnt++;
      if (c < NV + 2 && voice_trig != '0) trig_early++;
      if (c == NV + 2) trig_at = voice_trig;
      if (c == NV + 1 && tick_commit) tick = 1'b1;
    end
  endtask

  task automatic run_event(input bit on, input int n, input int v, input int rs, input bit tc,
                           output logic [NV-1:0] ot, output logic [NV-1:0] et,
                           output int od, output int ed, output bit rok, output int early);
    model_event(on, n, v, rs, et, ed);
    do_event(on, n, v, rs, tc, ot, od, rok, early);
  endtask

  task automatic apply_reset();
    reset_n = 1'b0; ev_valid = 1'b0; tick = 1'b0;
    step(); step();
    reset_n = 1'b1;
    step();
    model_clear();
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (ev_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b required 1", ev_ready); end
    checks++; if ({voice_busy, voice_gate, voice_trig} !== '0) begin errors++;
      $display("FAIL reset_flags: busy/gate/trig got %h required 0", {voice_busy, voice_gate, voice_trig}); end
    checks++; if ({voice_note, voice_vel, drop_pulse} !== '0) begin errors++;
      $display("FAIL reset_data: note/vel/drop got %h required 0", {voice_note, voice_vel, drop_pulse}); end
  endtask

  task automatic test_first_note();
    logic [NV-1:0] ot, et; int od, ed, early; bit rok;
    apply_reset();
    run_event(1, 60, 100, 0, 0, ot, et, od, ed, rok, early);
    checks++; if (ot !== 4'b0001 || early != 0) begin errors++;
      $display("FAIL first_trig: trig@%0d=%b early=%0d required 0001 early=0", NV + 2, ot, early); end
    checks++; if (!rok) begin errors++; $display("FAIL first_ready_window: got bad ev_ready window required low for %0d cycles", NV + 1); end
    checks++; if (voice_gate !== 4'b0001 || voice_note[6:0] !== 7'd60 || voice_vel[6:0] !== 7'd100) begin errors++;
      $display("FAIL first_voice: gate=%b note=%0d vel=%0d required 0001 60 100", voice_gate, voice_note[6:0], voice_vel[6:0]); end
  endtask

  task automatic test_full_pool();
    logic [NV-1:0] ot, et; int od, ed, early; bit rok;
    int notes[4] = '{60, 62, 64, 67};
    apply_reset();
    foreach (notes[j]) run_event(1, notes[j], 90, 0, 0, ot, et, od, ed, rok, early);
    checks++; if (voice_busy !== 4'b1111) begin errors++; $display("FAIL pool_fill: busy=%b required 1111", voice_busy); end
    run_event(1, 69, 70, 0, 0, ot, et, od, ed, rok, early);
`ifdef VOICE_STEAL_EN
    checks++; if (ot !== 4'b0001 || od != 0 || voice_note[6:0] !== 7'd69) begin errors++;
      $display("FAIL steal: trig=%b drop=%0d note0=%0d required 0001 0 69", ot, od, voice_note[6:0]); end
`else
    checks++; if (ot !== 4'b0000 || od != 1) begin errors++;
      $display("FAIL drop: trig=%b drop_cnt=%0d required 0000 1", ot, od); end
`endif
    checks++; if ((voice_note & busy_mask()) !== exp_notes()) begin errors++;
      $display("FAIL pool_notes: got %h required %h", voice_note & busy_mask(), exp_notes()); end
  endtask

  task automatic test_release();
    logic [NV-1:0] ot, et; int od, ed, early; bit rok;
    apply_reset();
    run_event(1, 60, 100, 0, 0, ot, et, od, ed, rok, early);
    run_event(0, 60, 0, 1, 0, ot, et, od, ed, rok, early);
    checks++; if (voice_gate !== 4'b0000 || voice_busy !== 4'b0001 || ot !== 4'b0000) begin errors++;
      $display("FAIL release_start: gate=%b busy=%b trig=%b required 0000 0001 0000", voice_gate, voice_busy, ot); end
    rel_sel = 2'd3;
    do_ticks(7);
    checks++; if (voice_busy !== 4'b0001) begin errors++; $display("FAIL release_7ticks: busy=%b required 0001", voice_busy); end
    do_ticks(1);
    checks++; if (voice_busy !== 4'b0000) begin errors++; $display("FAIL release_8ticks: busy=%b required 0000", voice_busy); end
  endtask

  task automatic test_retrig();
    logic [NV-1:0] ot, et; int od, ed, early; bit rok;
    apply_reset();
    run_event(1, 60, 100, 0, 0, ot, et, od, ed, rok, early);
    run_event(1, 60, 20, 0, 0, ot, et, od, ed, rok, early);
    checks++; if (ot !== 4'b0001 || voice_busy !== 4'b0001 || voice_vel[6:0] !== 7'd20) begin errors++;
      $display("FAIL retrig: trig=%b busy=%b vel0=%0d required 0001 0001 20", ot, voice_busy, voice_vel[6:0]); end
  endtask

  task automatic test_vel0_and_unmatched();
    logic [NV-1:0] ot, et; int od, ed, early; bit rok;
    logic [3*NV+14*NV-1:0] snap;
    apply_reset();
    run_event(1, 60, 100, 0, 0, ot, et, od, ed, rok, early);
    run_event(1, 60, 0, 2, 0, ot, et, od, ed, rok, early);
    checks++; if (voice_gate !== 4'b0000 || voice_busy !== 4'b0001 || ot !== 4'b0000) begin errors++;
      $display("FAIL vel0_off: gate=%b busy=%b trig=%b required 0000 0001 0000", voice_gate, voice_busy, ot); end
    snap = {voice_gate, voice_busy, voice_trig, voice_note, voice_vel};
    run_event(0, 72, 0, 0, 0, ot, et, od, ed, rok, early);
    checks++; if ({voice_gate, voice_busy, voice_trig, voice_note, voice_vel} !== snap || od != 0 || ot !== '0) begin errors++;
      $display("FAIL unmatched_off: outputs=%h drop=%0d required %h 0", {voice_gate, voice_busy, voice_trig, voice_note, voice_vel}, od, snap); end
  endtask

  task automatic test_back_to_back();
    logic [NV-1:0] ot, et, ta; int od, ed, early; bit rok, rok_a;
    apply_reset();
    model_event(1, 60, 100, 0, et, ed);
    ev_note_on = 1'b1; ev_note = 7'd60; ev_vel = 7'd100; ev_valid = 1'b1;
    rok_a = 1; ta = '0;
    for (int c = 1; c <= NV + 2; c++) begin
      step();
      if (c == 1) begin ev_note = 7'd62; ev_vel = 7'd50; end
      if (c <= NV + 1 && ev_ready) rok_a = 0;
      if (c == NV + 2) ta = voice_trig;
    end
    checks++; if (!rok_a || ta !== 4'b0001) begin errors++;
      $display("FAIL b2b_first: ready_ok=%b trig=%b required 1 0001", rok_a, ta); end
    run_event(1, 62, 50, 0, 0, ot, et, od, ed, rok, early);
    checks++; if (!rok || ot !== 4'b0010 || voice_busy !== 4'b0011) begin errors++;
      $display("FAIL b2b_second: ready_ok=%b trig=%b busy=%b required 1 0010 0011", rok, ot, voice_busy); end
  endtask

  task automatic test_commit_tick();
    logic [NV-1:0] ot, et; int od, ed, early; bit rok;
    int notes[4] = '{60, 62, 64, 67};
    apply_reset();
    foreach (notes[j]) run_event(1, notes[j], 90, 0, 0, ot, et, od, ed, rok, early);
    run_event(0, 60, 0, 0, 0, ot, et, od, ed, rok, early);
    do_ticks(RT - 1);
    run_event(1, 70, 80, 0, 1, ot, et, od, ed, rok, early);
    checks++; if (ot !== 4'b0001 || voice_gate !== 4'b1111 || voice_note[6:0] !== 7'd70) begin errors++;
      $display("FAIL commit_tick: trig=%b gate=%b note0=%0d required 0001 1111 70", ot, voice_gate, voice_note[6:0]); end
  endtask

  task automatic test_reset_mid_scan();
    logic [NV-1:0] ot, et, tor; int od, ed, early; bit rok;
    apply_reset();
    run_event(1, 60, 100, 0, 0, ot, et, od, ed, rok, early);
    ev_note_on = 1'b1; ev_note = 7'd62; ev_vel = 7'd40; ev_valid = 1'b1;
    step(); ev_valid = 1'b0; step();
    reset_n = 1'b0;
    #1;
    checks++; if (voice_busy !== 4'b0000 || ev_ready !== 1'b1) begin errors++;
      $display("FAIL reset_mid_scan: busy=%b ready=%b required 0000 1", voice_busy, ev_ready); end
    step(); reset_n = 1'b1; model_clear();
    tor = '0;
    for (int c = 0; c < NV + 3; c++) begin step(); tor |= voice_trig; end
    checks++; if (tor !== '0 || voice_busy !== '0) begin errors++;
      $display("FAIL reset_discard: trig_seen=%b busy=%b required 0000 0000", tor, voice_busy); end
    run_event(1, 64, 30, 0, 0, ot, et, od, ed, rok, early);
    checks++; if (ot !== 4'b0001 || voice_note[6:0] !== 7'd64) begin errors++;
      $display("FAIL after_reset_event: trig=%b note0=%0d required 0001 64", ot, voice_note[6:0]); end
  endtask

  task automatic test_random();
    logic [NV-1:0] ot, et; int od, ed, early; bit rok;
    bit on; int n, v, rs;
    apply_reset();
    for (int k = 0; k < 120; k++) begin
      on = ($urandom_range(0, 9) < 6);
      n  = 60 + $urandom_range(0, 7);
      v  = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 127);
      rs = $urandom_range(0, 3);
      run_event(on, n, v, rs, 0, ot, et, od, ed, rok, early);
      checks++; if (ot !== et || od != ed || !rok || early != 0) begin errors++;
        $display("FAIL rnd_event%0d: trig=%b drop=%0d rok=%b early=%0d required trig=%b drop=%0d rok=1 early=0",
                 k, ot, od, rok, early, et, ed); end
      checks++; if (voice_busy !== exp_busy() || voice_gate !== exp_gate()) begin errors++;
        $display("FAIL rnd_state%0d: busy=%b gate=%b required %b %b", k, voice_busy, voice_gate, exp_busy(), exp_gate()); end
      checks++; if ((voice_note & busy_mask()) !== exp_notes() || (voice_vel & busy_mask()) !== exp_vels()) begin errors++;
        $display("FAIL rnd_data%0d: note=%h vel=%h required %h %h", k, voice_note & busy_mask(),
                 voice_vel & busy_mask(), exp_notes(), exp_vels()); end
      do_ticks($urandom_range(0, 3));
      checks++; if (voice_busy !== exp_busy()) begin errors++;
        $display("FAIL rnd_ticks%0d: busy=%b required %b", k, voice_busy, exp_busy()); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    model_clear();
    step();
    test_reset();
    test_first_note();
    test_full_pool();
    test_release();
    test_retrig();
    test_vel0_and_unmatched();
    test_back_to_back();
    test_commit_tick();
    test_reset_mid_scan();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
